// File: rtl/clock_pkg.sv
// Shared types and widths for the mm:ss clock/timer blocks.
`default_nettype none

package clock_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int SEC_MAX = 59;
  localparam int CNT_W   = 6;

  // Width of a counter that runs 0..ticks-1.
  function automatic int tick_cnt_w(input int ticks);
    return (ticks < 2) ? 1 : $clog2(ticks);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wrap_counter.sv
// Modulo-(N+1) up/down counter with saturating parallel load and underflow flag.
`default_nettype none

module wrap_counter
  import clock_pkg::*;
#(
  parameter int N = 59
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] TOP = CNT_W'(N);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (load) begin
      value <= (load_val > TOP) ? TOP : load_val;
    end else if (dec) begin
      value <= (value == '0) ? TOP : value - CNT_W'(1);
    end else if (inc) begin
      value <= (value == TOP) ? '0 : value + CNT_W'(1);
    end
  end

  assign underflow = dec && !load && (value == '0);

endmodule

`default_nettype wire

// File: rtl/countdown_min_sec.sv
// Down-counting mm:ss timer with SET/RUN/PAUSE/DONE control and timed alarm.
// Optional build macro AUTO_RELOAD_EN: reload last preset and restart when leaving DONE.
`default_nettype none

module countdown_min_sec
  import clock_pkg::*;
#(
  parameter int MAX_MIN     = 59,
  parameter int ALARM_TICKS = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             load,
  input  logic             setting_min,
  input  logic             setting_sec,
  input  logic             load_data,
  input  logic [CNT_W-1:0] data_min,
  input  logic [CNT_W-1:0] data_sec,
  input  logic             start,
  output logic [CNT_W-1:0] count_min,
  output logic [CNT_W-1:0] count_sec,
  output logic             borrow_min,
  output logic             running,
  output logic             done
);

  localparam int              AW         = tick_cnt_w(ALARM_TICKS);
  localparam logic [AW-1:0]   ALARM_LAST = AW'(ALARM_TICKS - 1);

  state_t           state, state_nx;
  logic [AW-1:0]    alarm_cnt, alarm_nx;
  logic             cnt_load, inc_sec, inc_min, run_dec;
  logic             sec_uf, min_uf, min_dec, borrow_nx, nonzero;
  logic [CNT_W-1:0] load_min_val, load_sec_val;

  assign nonzero = (count_min != '0) || (count_sec != '0);
  assign min_dec = sec_uf;
  // A seconds wrap is only a borrow when minutes actually absorbed it.
  assign borrow_nx = sec_uf && !min_uf;

`ifdef AUTO_RELOAD_EN
  logic [CNT_W-1:0] preset_min, preset_sec;
  logic             preset_nonzero;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      preset_min <= '0;
      preset_sec <= '0;
    end else if (state == S_SET && !load) begin
      preset_min <= count_min;
      preset_sec <= count_sec;
    end
  end

  assign preset_nonzero = (preset_min != '0) || (preset_sec != '0);
  assign load_min_val   = (state == S_DONE) ? preset_min : data_min;
  assign load_sec_val   = (state == S_DONE) ? preset_sec : data_sec;
`else
  assign load_min_val = data_min;
  assign load_sec_val = data_sec;
`endif

  wrap_counter #(.N(SEC_MAX)) u_sec (
    .clock     (clock),
    .reset_n   (reset_n),
    .inc       (inc_sec),
    .dec       (run_dec),
    .load      (cnt_load),
    .load_val  (load_sec_val),
    .value     (count_sec),
    .underflow (sec_uf)
  );

  wrap_counter #(.N(MAX_MIN)) u_min (
    .clock     (clock),
    .reset_n   (reset_n),
    .inc       (inc_min),
    .dec       (min_dec),
    .load      (cnt_load),
    .load_val  (load_min_val),
    .value     (count_min),
    .underflow (min_uf)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      alarm_cnt  <= '0;
      borrow_min <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      alarm_cnt  <= alarm_nx;
      borrow_min <= borrow_nx;
      running    <= (state_nx == S_RUN);
      done       <= (state_nx == S_DONE);
    end
  end

  always_comb begin
    state_nx = state;
    alarm_nx = '0;
    cnt_load = 1'b0;
    inc_sec  = 1'b0;
    inc_min  = 1'b0;
    run_dec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (load)                  state_nx = S_SET;
        else if (start && nonzero) state_nx = S_RUN;
      end
      S_SET: begin
        // Edits only apply while load is still held, so the exit cycle is clean.
        if (!load) begin
          state_nx = S_IDLE;
        end else if (load_data) begin
          cnt_load = 1'b1;
        end else begin
          inc_sec = setting_sec;
          inc_min = setting_min;
        end
      end
      S_RUN: begin
        if (start) begin
          state_nx = S_PAUSE;
        end else if (tick && nonzero) begin
          run_dec = 1'b1;
          if (count_min == '0 && count_sec == CNT_W'(1)) state_nx = S_DONE;
        end
      end
      S_PAUSE: begin
        if (start)     state_nx = S_RUN;
        else if (load) state_nx = S_SET;
      end
      S_DONE: begin
        alarm_nx = alarm_cnt;
        if (start || (tick && alarm_cnt == ALARM_LAST)) begin
          alarm_nx = '0;
`ifdef AUTO_RELOAD_EN
          cnt_load = 1'b1;
          state_nx = preset_nonzero ? S_RUN : S_IDLE;
`else
          state_nx = S_IDLE;
`endif
        end else if (tick) begin
          alarm_nx = alarm_cnt + AW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_countdown_min_sec.sv
// Directed plus randomized bench for countdown_min_sec against a total-seconds reference model.
`default_nettype none

module tb_countdown_min_sec;

  localparam int MAX_MIN     = 59;
  localparam int ALARM_TICKS = 10;
  localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic       clock = 1'b0;
  logic       reset_n, tick, load, setting_min, setting_sec, load_data, start;
  logic [5:0] data_min, data_sec, count_min, count_sec;
  logic       borrow_min, running, done;

  int checks = 0, failures = 0;
  int m_state, m_min, m_sec, m_alarm, p_min, p_sec;
  bit m_borrow;

  always #5 clock = ~clock;

  countdown_min_sec #(.MAX_MIN(MAX_MIN), .ALARM_TICKS(ALARM_TICKS)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .tick        (tick),
    .load        (load),
    .setting_min (setting_min),
    .setting_sec (setting_sec),
    .load_data   (load_data),
    .data_min    (data_min),
    .data_sec    (data_sec),
    .start       (start),
    .count_min   (count_min),
    .count_sec   (count_sec),
    .borrow_min  (borrow_min),
    .running     (running),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    check("count_min", {26'd0, count_min}, m_min);
    check("count_sec", {26'd0, count_sec}, m_sec);
    check("running",   {31'd0, running},   (m_state == M_RUN) ? 1 : 0);
    check("done",      {31'd0, done},      (m_state == M_DONE) ? 1 : 0);
    check("borrow",    {31'd0, borrow_min}, {31'd0, m_borrow});
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_min = 0; m_sec = 0; m_alarm = 0; m_borrow = 0;
    p_min = 0; p_sec = 0;
  endtask

  task automatic model_leave_done();
    m_alarm = 0;
`ifdef AUTO_RELOAD_EN
    m_min = p_min;
    m_sec = p_sec;
    m_state = (p_min * 60 + p_sec != 0) ? M_RUN : M_IDLE;
`else
    m_state = M_IDLE;
`endif
  endtask

  task automatic model_step();
    int total;
    m_borrow = 0;
    total = m_min * 60 + m_sec;
    case (m_state)
      M_IDLE: begin
        if (load) m_state = M_SET;
        else if (start && total != 0) m_state = M_RUN;
      end
      M_SET: begin
        if (!load) begin
          p_min = m_min; p_sec = m_sec; m_state = M_IDLE;
        end else if (load_data) begin
          m_min = (int'(data_min) > MAX_MIN) ? MAX_MIN : int'(data_min);
          m_sec = (int'(data_sec) > 59) ? 59 : int'(data_sec);
        end else begin
          if (setting_min) m_min = (m_min + 1) % (MAX_MIN + 1);
          if (setting_sec) m_sec = (m_sec + 1) % 60;
        end
      end
      M_RUN: begin
        if (start) m_state = M_PAUSE;
        else if (tick && total != 0) begin
          if (m_sec == 0) m_borrow = 1;
          total = total - 1;
          m_min = total / 60;
          m_sec = total % 60;
          if (total == 0) begin m_state = M_DONE; m_alarm = 0; end
        end
      end
      M_PAUSE: begin
        if (start) m_state = M_RUN;
        else if (load) m_state = M_SET;
      end
      default: begin
        if (start) model_leave_done();
        else if (tick) begin
          m_alarm++;
          if (m_alarm == ALARM_TICKS) model_leave_done();
        end
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_model();
    tick = 0; setting_min = 0; setting_sec = 0; load_data = 0; start = 0;
  endtask

  task automatic preset(input int mn, input int sc);
    load = 1; cycle();
    load_data = 1; data_min = 6'(mn); data_sec = 6'(sc); cycle();
    load = 0; cycle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin tick = 1; cycle(); end
  endtask

  initial begin
    reset_n = 0; tick = 0; load = 0; setting_min = 0; setting_sec = 0;
    load_data = 0; start = 0; data_min = 0; data_sec = 0;
    model_reset();
    #17;
    check_model();
    reset_n = 1;

    // Button preset with seconds wrap.
    load = 1; cycle();
    for (int i = 0; i < 3; i++) begin setting_min = 1; cycle(); end
    for (int i = 0; i < 61; i++) begin setting_sec = 1; cycle(); end
    load = 0; cycle();
    check("btn_min", {26'd0, count_min}, 3);
    check("btn_sec", {26'd0, count_sec}, 1);
    check("btn_idle", {30'd0, running, done}, 0);

    // Bus preset clamp.
    preset(63, 60);
    check("clamp_min", {26'd0, count_min}, 59);
    check("clamp_sec", {26'd0, count_sec}, 59);

    // Borrow and expiry.
    preset(1, 0);
    start = 1; cycle();
    tick = 1; cycle();
    check("borrow_sec", {26'd0, count_sec}, 59);
    check("borrow_pulse", {31'd0, borrow_min}, 1);
    cycle();
    check("borrow_once", {31'd0, borrow_min}, 0);
    ticks(59);
    check("expire_done", {30'd0, running, done}, 1);

    // Alarm timeout.
    ticks(9);
    check("alarm_hold", {31'd0, done}, 1);
    ticks(1);
    check("alarm_timeout", {31'd0, done}, 0);
    if (m_state == M_RUN) begin start = 1; cycle(); end

    // Pause priority over coincident tick.
    preset(0, 10);
    start = 1; cycle();
    start = 1; tick = 1; cycle();
    check("pause_sec", {26'd0, count_sec}, 10);
    check("pause_run", {31'd0, running}, 0);
    ticks(5);
    start = 1; cycle();
    ticks(1);
    check("resume_sec", {26'd0, count_sec}, 9);

    // Acknowledge after three alarm ticks.
    ticks(9);
    ticks(3);
    start = 1; tick = 1; cycle();
    check("ack_done", {31'd0, done}, 0);
`ifdef AUTO_RELOAD_EN
    check("ack_reload_sec", {26'd0, count_sec}, 10);
    start = 1; cycle();
    preset(0, 5);
    start = 1; cycle();
    ticks(5);
    start = 1; cycle();
    check("reload_run", {31'd0, running}, 1);
    check("reload_sec", {26'd0, count_sec}, 5);
    start = 1; cycle();
`endif

    // Asynchronous reset mid-count.
    preset(2, 30);
    start = 1; cycle();
    ticks(1);
    cycle();
    #2 reset_n = 0;
    #1;
    model_reset();
    check_model();
    check("rst_min", {26'd0, count_min}, 0);
    @(negedge clock);
    reset_n = 1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) load = ~load;
      setting_min = ($urandom_range(0, 3) == 0);
      setting_sec = ($urandom_range(0, 3) == 0);
      load_data   = ($urandom_range(0, 7) == 0);
      data_min    = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 1));
      data_sec    = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 5));
      tick        = ($urandom_range(0, 1) == 0);
      start       = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
